// File: rtl/nonce_scan_ctrl.sv
// nonce_scan_ctrl: sweeps a nonce range through one two-phase SHA-256 core and queues winning nonces
// Ports: clk/reset_n (async, active-low); start/abort job control; midstate, tail, nonce_start,
//   nonce_end, target job inputs; busy/done/aborted/nonces_done status; hash_* hasher interface
//   (this block owns the hasher reset); hit_valid/hit_ready/hit_nonce/hit_drop hit FIFO to the host.
// Build option: define HIT_HASH_EN to store each hit's digest and expose it on hit_hash.
module nonce_scan_ctrl #(
  parameter int HIT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] midstate [8],
  input  logic [31:0] tail [3],
  input  logic [31:0] nonce_start,
  input  logic [31:0] nonce_end,
  input  logic [31:0] target [8],
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [32:0] nonces_done,
  output logic        hash_rst_n,
  output logic        hash_start,
  output logic [31:0] hash_inh [8],
  output logic [31:0] hash_msg [4],
  input  logic [31:0] hash_out [8],
  input  logic        hash_done,
  output logic        hit_valid,
  input  logic        hit_ready,
  output logic [31:0] hit_nonce,
  output logic        hit_drop
`ifdef HIT_HASH_EN
  ,
  output logic [31:0] hit_hash [8]
`endif
);
  localparam int AW = $clog2(HIT_DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, RESTART, FIN} state_t;
  state_t state;
  logic [31:0] last;
  logic [255:0] tgt, dig;
  logic abort_flag, hit, full, pop, take, push, drop;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] fifo_nonce [HIT_DEPTH];
  always_comb begin
    hit = dig <= tgt;
    full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    hit_valid = wr_ptr != rd_ptr;
    pop = hit_valid && hit_ready;
    take = state == CHECK && !abort && hit;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the hit
    push = take && (!full || pop);
    drop = take && full && !pop;
    hit_nonce = fifo_nonce[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      hash_start <= 1'b0;
      hash_rst_n <= 1'b0;
      hit_drop <= 1'b0;
      nonces_done <= '0;
      abort_flag <= 1'b0;
      last <= '0;
      tgt <= '0;
      dig <= '0;
      hash_inh <= '{default: '0};
      hash_msg <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
      hash_start <= 1'b0;
      hash_rst_n <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (drop) hit_drop <= 1'b1;
      case (state)
        IDLE: if (start) begin
          hash_inh <= midstate;
          hash_msg <= '{tail[0], tail[1], tail[2], nonce_start};
          last <= nonce_end;
          tgt <= {target[0], target[1], target[2], target[3], target[4], target[5], target[6], target[7]};
          nonces_done <= '0;
          hit_drop <= 1'b0;
          abort_flag <= 1'b0;
          busy <= 1'b1;
          hash_start <= 1'b1;
          state <= ISSUE;
        end
        ISSUE, WAIT: if (abort) begin
          abort_flag <= 1'b1;
          hash_rst_n <= 1'b0;
          state <= RESTART;
        end else if (state == ISSUE) state <= WAIT;
        else if (hash_done) begin
          dig <= {hash_out[0], hash_out[1], hash_out[2], hash_out[3], hash_out[4], hash_out[5], hash_out[6], hash_out[7]};
          nonces_done <= nonces_done + 33'd1;
          state <= CHECK;
        end
        CHECK: begin
          abort_flag <= abort;
          hash_rst_n <= 1'b0;
          state <= RESTART;
        end
        // the hasher only leaves DONE through reset, so every hash ends with one low cycle here
        RESTART: if (abort_flag || hash_msg[3] == last) begin
          done <= 1'b1;
          aborted <= abort_flag;
          state <= FIN;
        end else begin
          hash_msg[3] <= hash_msg[3] + 32'd1;
          hash_start <= 1'b1;
          state <= ISSUE;
        end
        FIN: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (push) fifo_nonce[wr_ptr[AW-1:0]] <= hash_msg[3];
`ifdef HIT_HASH_EN
  logic [255:0] fifo_hash [HIT_DEPTH];
  always_ff @(posedge clk) if (push) fifo_hash[wr_ptr[AW-1:0]] <= dig;
  always_comb for (int i = 0; i < 8; i++) hit_hash[i] = fifo_hash[rd_ptr[AW-1:0]][255-32*i -: 32];
`endif
endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// tb_nonce_scan_ctrl: randomized scoreboard bench for nonce_scan_ctrl with a behavioural hasher
module tb_nonce_scan_ctrl;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset_n, start = 1'b0, abort = 1'b0, hit_ready = 1'b0;
  logic [31:0] midstate [8], tail [3], target [8], hash_out [8], hash_inh [8], hash_msg [4];
  logic [31:0] nonce_start = '0, nonce_end = '0, hit_nonce;
  logic busy, done, aborted, hash_rst_n, hash_start, hit_valid, hit_drop;
  logic hash_done = 1'b0;
  logic [32:0] nonces_done;
`ifdef HIT_HASH_EN
  logic [31:0] hit_hash [8];
`endif
  always #5 clk = ~clk;

  nonce_scan_ctrl #(.HIT_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .midstate(midstate), .tail(tail), .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .busy(busy), .done(done), .aborted(aborted), .nonces_done(nonces_done),
    .hash_rst_n(hash_rst_n), .hash_start(hash_start), .hash_inh(hash_inh), .hash_msg(hash_msg),
    .hash_out(hash_out), .hash_done(hash_done),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_nonce(hit_nonce), .hit_drop(hit_drop)
`ifdef HIT_HASH_EN
    , .hit_hash(hit_hash)
`endif
  );

  typedef struct {logic [31:0] n; logic [255:0] d;} hit_t;
  typedef struct {logic ab; logic [32:0] cnt; int lows; logic drop;} fin_t;
  logic [31:0] q_iss [$];
  hit_t q_hit [$];
  fin_t q_fin [$];
  int vecs = 0, errs = 0, lows = 0, dones = 0;
  logic [31:0] j_mid [8], j_tail [3];
  hit_t hm;
  fin_t fm;

  // stand-in digest: depends on midstate word 0, tail word 0 and the nonce
  function automatic logic [255:0] dig_f(input logic [31:0] m0, input logic [31:0] t0, input logic [31:0] n);
    logic [255:0] r;
    logic [31:0] w;
    w = (n * 32'h9E3779B1) ^ m0 ^ t0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = w ^ (32'(i) * 32'h27D4EB2F);
    return r;
  endfunction

  function automatic logic [255:0] pk8(input logic [31:0] a [8]);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = a[i];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // behavioural hasher: sits in DONE until its reset is pulsed
  logic hbusy = 1'b0;
  int hcnt = 0;
  logic [255:0] hreg = '0;
  always @(posedge clk or negedge hash_rst_n)
    if (!hash_rst_n) begin
      hash_done <= 1'b0;
      hbusy <= 1'b0;
    end else if (hash_start && !hbusy && !hash_done) begin
      hbusy <= 1'b1;
      hcnt <= $urandom_range(2, 5);
      hreg <= dig_f(hash_inh[0], hash_msg[0], hash_msg[3]);
    end else if (hbusy) begin
      if (hcnt <= 1) begin
        hbusy <= 1'b0;
        hash_done <= 1'b1;
      end else hcnt <= hcnt - 1;
    end
  always_comb for (int i = 0; i < 8; i++) hash_out[i] = hreg[255-32*i -: 32];

  // monitor: pops the scoreboard whenever the DUT presents something
  always @(negedge clk) begin
    if (!reset_n) lows = 0;
    else begin
      if (busy && !hash_rst_n) lows++;
      if (hash_start) begin
        if (q_iss.size() == 0) begin
          vecs++; errs++;
          $display("FAIL issue_unexpected: got hash_start nonce %h expected none", hash_msg[3]);
        end else chk("issue_nonce", hash_msg[3], q_iss.pop_front());
        chk("issue_rst_high", hash_rst_n, 1'b1);
        chk("issue_inh", pk8(hash_inh), pk8(j_mid));
        chk("issue_tail", {hash_msg[0], hash_msg[1], hash_msg[2]}, {j_tail[0], j_tail[1], j_tail[2]});
      end
      if (hit_valid && hit_ready) begin
        if (q_hit.size() == 0) begin
          vecs++; errs++;
          $display("FAIL hit_unexpected: got nonce %h expected none", hit_nonce);
        end else begin
          hm = q_hit.pop_front();
          chk("hit_nonce", hit_nonce, hm.n);
`ifdef HIT_HASH_EN
          chk("hit_hash", pk8(hit_hash), hm.d);
`endif
        end
      end
      if (done) begin
        dones++;
        if (q_fin.size() == 0) begin
          vecs++; errs++;
          $display("FAIL done_unexpected: got done pulse expected none");
        end else begin
          fm = q_fin.pop_front();
          chk("done_aborted", aborted, fm.ab);
          chk("done_count", nonces_done, fm.cnt);
          chk("done_rst_lows", 32'(lows), 32'(fm.lows));
          chk("done_hit_drop", hit_drop, fm.drop);
        end
        lows = 0;
      end
    end
  end

  task automatic rnd_job();
    for (int i = 0; i < 8; i++) j_mid[i] = $urandom;
    for (int i = 0; i < 3; i++) j_tail[i] = $urandom;
  endtask

  task automatic apply_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tg);
    for (int i = 0; i < 8; i++) begin
      midstate[i] = j_mid[i];
      target[i] = tg[255-32*i -: 32];
    end
    for (int i = 0; i < 3; i++) tail[i] = j_tail[i];
    nonce_start = s;
    nonce_end = e;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    // the job is latched; anything on the inputs now must be ignored
    for (int i = 0; i < 8; i++) begin
      midstate[i] = $urandom;
      target[i] = $urandom;
    end
    for (int i = 0; i < 3; i++) tail[i] = $urandom;
    nonce_start = $urandom;
    nonce_end = $urandom;
  endtask

  // amode: 0 none, 1 abort while ISSUE of nonce an, 2 abort while WAIT of nonce an
  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tg,
                         input logic rdy, input int amode, input logic [31:0] an, input logic drain);
    int iss = 0, cnt = 0, d0 = dones;
    logic drop = 1'b0, ab = 1'b0;
    logic [31:0] n = s;
    hit_t h;
    fin_t f;
    hit_ready = rdy;
    forever begin
      q_iss.push_back(n);
      iss++;
      if (amode != 0 && n == an) begin
        ab = 1'b1;
        break;
      end
      cnt++;
      h.n = n;
      h.d = dig_f(j_mid[0], j_tail[0], n);
      if (h.d <= tg) begin
        if (rdy || q_hit.size() < D) q_hit.push_back(h);
        else drop = 1'b1;
      end
      if (n == e) break;
      n++;
    end
    f.ab = ab; f.cnt = 33'(cnt); f.lows = iss; f.drop = drop;
    q_fin.push_back(f);
    apply_job(s, e, tg);
    if (amode != 0) begin
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (hash_start && hash_msg[3] == an) break;
      end
      if (amode == 1) begin
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end else begin
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end
    end
    for (int k = 0; k < 4000 && dones == d0; k++) begin
      @(posedge clk); #1;
    end
    if (dones == d0) begin
      vecs++; errs++;
      $display("FAIL job_timeout: got no done pulse expected done for range %h..%h", s, e);
      q_fin.delete();
    end
    chk("issue_all_seen", 32'(q_iss.size()), 32'd0);
    q_iss.delete();
    if (drain) begin
      hit_ready = 1'b1;
      for (int k = 0; k < 40 && hit_valid; k++) begin
        @(posedge clk); #1;
      end
      chk("fifo_drained", 32'(q_hit.size()), 32'd0);
      q_hit.delete();
    end
  endtask

  initial begin
    logic [255:0] tg;
    logic [31:0] s;
    int len;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin midstate[i] = '0; target[i] = '0; end
    for (int i = 0; i < 3; i++) tail[i] = '0;
    #2 reset_n = 1'b0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", {done, aborted, hash_start}, 3'b000);
    chk("rst_hash_rst_n", hash_rst_n, 1'b0);
    chk("rst_hit", {hit_valid, hit_drop}, 2'b00);
    chk("rst_count", nonces_done, 33'd0);
    chk("rst_inh", pk8(hash_inh), 256'd0);
    chk("rst_msg", {hash_msg[0], hash_msg[1], hash_msg[2], hash_msg[3]}, 128'd0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_hash_rst_n", hash_rst_n, 1'b1);

    rnd_job(); run_job(32'd5, 32'd7, '1, 1'b1, 0, 0, 1'b1);
    rnd_job(); run_job(32'd0, 32'd3, '0, 1'b1, 0, 0, 1'b1);
    rnd_job(); run_job(32'hFFFFFFFE, 32'h00000001, rnd256(), 1'b1, 0, 0, 1'b1);
    rnd_job(); run_job(32'd0, 32'd5, '1, 1'b0, 0, 0, 1'b1);
    rnd_job(); run_job(32'd0, 32'd9, rnd256(), 1'b1, 2, 32'd2, 1'b1);
    rnd_job(); run_job(32'd10, 32'd20, '1, 1'b1, 1, 32'd13, 1'b1);
    rnd_job(); tg = dig_f(j_mid[0], j_tail[0], 32'd42);
    run_job(32'd42, 32'd42, tg, 1'b1, 0, 0, 1'b1);
    run_job(32'd42, 32'd42, tg - 256'd1, 1'b1, 0, 0, 1'b1);
    for (int j = 0; j < 10; j++) begin
      s = (j % 2 == 1) ? 32'hFFFFFFFF - $urandom_range(0, 3) : $urandom;
      len = $urandom_range(0, 6);
      rnd_job();
      run_job(s, s + 32'(len), rnd256(), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              s + 32'($urandom_range(0, len)), 1'b1);
    end
    // leave the FIFO full with hit_drop set, then reset in the middle of a hash
    rnd_job(); run_job(32'd0, 32'd5, '1, 1'b0, 0, 0, 1'b0);
    chk("left_full", {hit_valid, hit_drop}, 2'b11);
    rnd_job();
    q_iss.push_back(32'd0);
    apply_job(32'd0, 32'd9, '0);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {busy, done, aborted, hash_start}, 4'b0000);
    chk("midrst_hash_rst_n", hash_rst_n, 1'b0);
    chk("midrst_fifo", {hit_valid, hit_drop}, 2'b00);
    chk("midrst_count", nonces_done, 33'd0);
    chk("midrst_msg", {hash_msg[0], hash_msg[1], hash_msg[2], hash_msg[3]}, 128'd0);
    q_iss.delete(); q_hit.delete(); q_fin.delete();
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release", hash_rst_n, 1'b1);
    rnd_job(); run_job(32'd7, 32'd7, '1, 1'b1, 0, 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
